ann_train_sequencer: RTL and testbench

//  Sequences the drowsiness-detector ANN (30x10b in, 5 hidden, 3x10b out) through training epochs and inference passes.

---
 rtl/ann_train_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_ann_train_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ann_train_sequencer.sv
// rtl/ann_train_sequencer.sv - training/inference pass sequencer for the drowsiness-detector ANN
//
// Walks an external sample store by index, runs one ANN pass per sample through a
// level Start / pulsed done handshake, scores each pass against the stored targets
// and stops on convergence, on the epoch limit, or on a watchdog fault.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   go              pulse, start a training run (wins over infer_req)
//   infer_req       pulse, one inference pass on live sensor data
//   samp_idx        sample store read index; tgt_in is its combinational read data
//   use_live        ANN input mux select, 1 = live sensor data
//   tgt_in          targets of samp_idx, packed [k*DW +: DW]
//   ann_start       level Start to the ANN, held until ann_done
//   ann_train       ANN training pin
//   ann_done        one-cycle pulse from the ANN, ann_out valid with it
//   ann_out         ANN outputs, packed [k*DW +: DW]
//   result          latched inference outputs
//   res_valid       one-cycle pulse when result updates
//   busy            run in progress
//   converged       last training run converged
//   fault           watchdog expired waiting for ann_done
//   epoch_cnt       completed epochs of the current/last run
//   epoch_err       (ERR_LOG_EN only) saturating total err of the last completed epoch
//
// Optional feature macro: ERR_LOG_EN adds the epoch_err output and its accumulator.
module ann_train_sequencer #(
  parameter int DW         = 10,
  parameter int N_OUT      = 3,
  parameter int N_SAMPLES  = 8,
  parameter int MAX_EPOCHS = 64,
  parameter int ERR_TOL    = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                go,
  input  logic                                infer_req,
  output logic [$clog2(N_SAMPLES)-1:0]        samp_idx,
  output logic                                use_live,
  input  logic [N_OUT*DW-1:0]                 tgt_in,
  output logic                                ann_start,
  output logic                                ann_train,
  input  logic                                ann_done,
  input  logic [N_OUT*DW-1:0]                 ann_out,
  output logic [N_OUT*DW-1:0]                 result,
  output logic                                res_valid,
  output logic                                busy,
  output logic                                converged,
  output logic                                fault,
  output logic [$clog2(MAX_EPOCHS+1)-1:0]     epoch_cnt
`ifdef ERR_LOG_EN
  ,
  output logic [DW+2+$clog2(N_SAMPLES)-1:0]   epoch_err
`endif
);

  localparam int IW  = $clog2(N_SAMPLES);
  localparam int EW  = $clog2(MAX_EPOCHS + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [IW-1:0]   LAST_IDX = IW'(N_SAMPLES - 1);
  localparam logic [EW-1:0]   EP_LIMIT = EW'(MAX_EPOCHS);
  localparam logic [TW-1:0]   WD_LAST  = TW'(TIMEOUT - 1);
  localparam logic [DW+1:0]   TOL      = (DW+2)'(ERR_TOL);

  typedef enum logic [2:0] {IDLE, SETUP, RUN, EVAL, EPOCH, DONE, FAULT} state_t;

  state_t                state;
  logic [N_OUT*DW-1:0]   cap;
  logic                  all_ok;
  logic [TW-1:0]         wd;
  logic [DW-1:0]         diff;
  logic [DW+1:0]         err;
  logic [EW-1:0]         ep_next;

  assign ep_next = epoch_cnt + EW'(1);

  // Sum of absolute differences between the captured outputs and the targets of
  // the current sample; the store is combinational so tgt_in is stable in EVAL.
  always_comb begin
    err  = '0;
    diff = '0;
    for (int k = 0; k < N_OUT; k++) begin
      diff = (cap[k*DW +: DW] >= tgt_in[k*DW +: DW]) ?
             cap[k*DW +: DW] - tgt_in[k*DW +: DW] :
             tgt_in[k*DW +: DW] - cap[k*DW +: DW];
      err  = err + {2'b00, diff};
    end
  end

`ifdef ERR_LOG_EN
  localparam int AW = DW + 2 + IW;
  logic [AW-1:0] acc;
  logic [AW:0]   acc_sum;
  assign acc_sum = {1'b0, acc} + (AW+1)'(err);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      samp_idx  <= '0;
      use_live  <= 1'b0;
      ann_start <= 1'b0;
      ann_train <= 1'b0;
      result    <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      converged <= 1'b0;
      fault     <= 1'b0;
      epoch_cnt <= '0;
      cap       <= '0;
      all_ok    <= 1'b0;
      wd        <= '0;
`ifdef ERR_LOG_EN
      acc       <= '0;
      epoch_err <= '0;
`endif
    end else begin
      res_valid <= 1'b0;
      case (state)
        // DONE and FAULT behave as IDLE towards new requests; status is held.
        IDLE, DONE, FAULT: begin
          if (go) begin
            state     <= SETUP;
            samp_idx  <= '0;
            epoch_cnt <= '0;
            converged <= 1'b0;
            fault     <= 1'b0;
            use_live  <= 1'b0;
            ann_train <= 1'b1;
            all_ok    <= 1'b1;
            busy      <= 1'b1;
`ifdef ERR_LOG_EN
            acc       <= '0;
`endif
          end else if (infer_req) begin
            state     <= SETUP;
            samp_idx  <= '0;
            fault     <= 1'b0;
            use_live  <= 1'b1;
            ann_train <= 1'b0;
            busy      <= 1'b1;
          end
        end
        SETUP: begin
          state     <= RUN;
          ann_start <= 1'b1;
          wd        <= '0;
        end
        RUN: begin
          if (ann_done) begin
            ann_start <= 1'b0;
            cap       <= ann_out;
            state     <= EVAL;
          end else if (wd == WD_LAST) begin
            ann_start <= 1'b0;
            ann_train <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b1;
            state     <= FAULT;
          end else begin
            wd <= wd + TW'(1);
          end
        end
        EVAL: begin
          if (use_live) begin
            result    <= cap;
            res_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            if (err > TOL) all_ok <= 1'b0;
`ifdef ERR_LOG_EN
            acc <= acc_sum[AW] ? '1 : acc_sum[AW-1:0];
`endif
            if (samp_idx == LAST_IDX) begin
              state <= EPOCH;
            end else begin
              samp_idx <= samp_idx + IW'(1);
              state    <= SETUP;
            end
          end
        end
        EPOCH: begin
          epoch_cnt <= ep_next;
`ifdef ERR_LOG_EN
          epoch_err <= acc;
`endif
          if (all_ok || ep_next == EP_LIMIT) begin
            converged <= all_ok;
            busy      <= 1'b0;
            ann_train <= 1'b0;
            state     <= DONE;
          end else begin
            samp_idx  <= '0;
            all_ok    <= 1'b1;
`ifdef ERR_LOG_EN
            acc       <= '0;
`endif
            state     <= SETUP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ann_train_sequencer.sv
// tb/tb_ann_train_sequencer.sv - self-checking bench for ann_train_sequencer
module tb_ann_train_sequencer;
  localparam int DW = 10, N_OUT = 3, NS = 8, ME = 4, TOL = 16, TO = 100;
  localparam int IW = 3, EW = 3;

  logic clk = 1'b0, rst_n = 1'b0, go = 1'b0, infer_req = 1'b0, ann_done = 1'b0;
  logic [IW-1:0] samp_idx;
  logic use_live, ann_start, ann_train, res_valid, busy, converged, fault;
  logic [N_OUT*DW-1:0] tgt_in, ann_out = '0, result;
  logic [EW-1:0] epoch_cnt;
`ifdef ERR_LOG_EN
  logic [DW+2+IW-1:0] epoch_err;
`endif

  int errors = 0, checks = 0;
  logic [N_OUT*DW-1:0] tgt_mem [NS];
  logic [N_OUT*DW-1:0] out_tab [ME][NS];

  assign tgt_in = tgt_mem[samp_idx];
  always #5 clk = ~clk;

  ann_train_sequencer #(.DW(DW), .N_OUT(N_OUT), .N_SAMPLES(NS), .MAX_EPOCHS(ME),
                        .ERR_TOL(TOL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .infer_req(infer_req), .samp_idx(samp_idx),
    .use_live(use_live), .tgt_in(tgt_in), .ann_start(ann_start), .ann_train(ann_train),
    .ann_done(ann_done), .ann_out(ann_out), .result(result), .res_valid(res_valid),
    .busy(busy), .converged(converged), .fault(fault), .epoch_cnt(epoch_cnt)
`ifdef ERR_LOG_EN
    , .epoch_err(epoch_err)
`endif
  );

  typedef struct {
    int d0, d1, d2;
    bit only3;
    int exp_ep;
    bit exp_conv;
    int exp_eerr;
  } vec_t;
  vec_t vecs [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_evt(inout int n);
    while (!(ann_start || !busy) && n < 40) begin
      step();
      n++;
    end
  endtask

  function automatic logic [N_OUT*DW-1:0] mk_out(input logic [N_OUT*DW-1:0] t,
                                                 input int d0, input int d1, input int d2);
    logic [N_OUT*DW-1:0] r;
    r[0*DW +: DW] = DW'(int'(t[0*DW +: DW]) + d0);
    r[1*DW +: DW] = DW'(int'(t[1*DW +: DW]) + d1);
    r[2*DW +: DW] = DW'(int'(t[2*DW +: DW]) + d2);
    return r;
  endfunction

  task automatic fill_tgt();
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < N_OUT; k++)
        tgt_mem[s][k*DW +: DW] = DW'($urandom_range(40, 700));
  endtask

  task automatic fill_delta(input int d0, input int d1, input int d2, input bit only3);
    for (int e = 0; e < ME; e++)
      for (int s = 0; s < NS; s++)
        out_tab[e][s] = (!only3 || s == 3) ? mk_out(tgt_mem[s], d0, d1, d2) : tgt_mem[s];
  endtask

  function automatic int sample_err(input int e, input int s);
    int sum = 0;
    for (int k = 0; k < N_OUT; k++) begin
      int o = int'(out_tab[e][s][k*DW +: DW]);
      int t = int'(tgt_mem[s][k*DW +: DW]);
      sum += (o > t) ? o - t : t - o;
    end
    return sum;
  endfunction

  // Reference: epochs repeat until every sample is within tolerance or the limit hits.
  task automatic model(output int ep, output bit conv, output int eerr);
    conv = 1'b0;
    ep   = ME;
    for (int e = 0; e < ME; e++) begin
      bit ok = 1'b1;
      eerr = 0;
      for (int s = 0; s < NS; s++) begin
        eerr += sample_err(e, s);
        if (sample_err(e, s) > TOL) ok = 1'b0;
      end
      if (ok) begin
        ep   = e + 1;
        conv = 1'b1;
        break;
      end
    end
  endtask

  task automatic train_run(input string name, input bit both, input bit poke,
                           output int ep, output bit conv);
    int p, n, mep, meerr;
    bit mconv;
    model(mep, mconv, meerr);
    go = 1'b1;
    infer_req = both;
    step();
    go = 1'b0;
    infer_req = 1'b0;
    n = 1;
    wait_evt(n);
    chk({name, "_go_lat"}, n, 2);
    p = 0;
    while (ann_start && busy) begin
      chk({name, "_idx"}, samp_idx, p % NS);
      chk({name, "_train"}, {ann_train, use_live}, 2'b10);
      if (p >= ME * NS) begin
        chk({name, "_overrun"}, p, ME * NS - 1);
        break;
      end
      repeat ($urandom_range(0, 3)) step();
      if (poke && p == 2) begin
        go = 1'b1;
        step();
        go = 1'b0;
      end
      ann_out = out_tab[p / NS][p % NS];
      ann_done = 1'b1;
      step();
      ann_done = 1'b0;
      ann_out = N_OUT*DW'($urandom);
      chk({name, "_start_drop"}, ann_start, 1'b0);
      p++;
      n = 1;
      wait_evt(n);
      if (n >= 40) begin
        chk({name, "_hang"}, n, 0);
        break;
      end
      if (ann_start) chk({name, "_done_lat"}, n, (p % NS == 0) ? 4 : 3);
    end
    chk({name, "_passes"}, p, mep * NS);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_epochs"}, epoch_cnt, mep);
    chk({name, "_conv"}, converged, mconv);
    chk({name, "_fault"}, fault, 1'b0);
    chk({name, "_train_off"}, ann_train, 1'b0);
`ifdef ERR_LOG_EN
    chk({name, "_eerr"}, epoch_err, meerr);
`endif
    ep   = int'(epoch_cnt);
    conv = converged;
  endtask

  task automatic infer_run(input string name, input logic [N_OUT*DW-1:0] val);
    int n, pulses;
    logic [N_OUT*DW-1:0] got;
    infer_req = 1'b1;
    step();
    infer_req = 1'b0;
    n = 1;
    wait_evt(n);
    chk({name, "_start"}, ann_start, 1'b1);
    chk({name, "_mux"}, {use_live, ann_train}, 2'b10);
    ann_out = val;
    ann_done = 1'b1;
    step();
    ann_done = 1'b0;
    ann_out = '0;
    pulses = 0;
    got = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (res_valid) begin
        pulses++;
        got = result;
      end
    end
    chk({name, "_pulses"}, pulses, 1);
    chk({name, "_result"}, got, val);
    chk({name, "_held"}, result, val);
    chk({name, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int ep, n, pass;
    bit conv;
    logic [N_OUT*DW-1:0] v;

    vecs[0] = '{2, 2, 2, 1'b0, 1, 1'b1, 48};
    vecs[1] = '{5, 5, 6, 1'b0, 1, 1'b1, 128};
    vecs[2] = '{5, 5, 7, 1'b0, 4, 1'b0, 136};
    vecs[3] = '{-16, 0, 0, 1'b0, 1, 1'b1, 128};
    vecs[4] = '{0, -17, 0, 1'b0, 4, 1'b0, 136};
    vecs[5] = '{0, 0, 0, 1'b0, 1, 1'b1, 0};
    vecs[6] = '{-3, 300, 0, 1'b0, 4, 1'b0, 2424};
    vecs[7] = '{-5, -5, -6, 1'b0, 1, 1'b1, 128};
    vecs[8] = '{6, 6, 5, 1'b1, 4, 1'b0, 17};
    vecs[9] = '{6, 6, 4, 1'b1, 1, 1'b1, 16};

    fill_tgt();
    repeat (3) step();
    chk("rst_outs", {samp_idx, use_live, ann_start, ann_train, res_valid, busy, converged, fault}, '0);
    chk("rst_result", result, '0);
    rst_n = 1'b1;
    step();
    chk("idle_outs", {busy, ann_start, epoch_cnt}, '0);

    ann_done = 1'b1;
    step();
    ann_done = 1'b0;
    step();
    chk("stray_done", {busy, ann_start, res_valid}, 3'b000);

    for (int i = 0; i < 10; i++) begin
      fill_delta(vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].only3);
      train_run($sformatf("vec%0d", i), 1'b0, 1'b0, ep, conv);
      chk($sformatf("vec%0d_tab_ep", i), ep, vecs[i].exp_ep);
      chk($sformatf("vec%0d_tab_conv", i), conv, vecs[i].exp_conv);
`ifdef ERR_LOG_EN
      chk($sformatf("vec%0d_tab_eerr", i), epoch_err, vecs[i].exp_eerr);
`endif
    end

    infer_run("infer", {10'd999, 10'd3, 10'd999});

    fill_delta(1, 1, 1, 1'b0);
    train_run("both", 1'b1, 1'b0, ep, conv);
    train_run("poke", 1'b0, 1'b1, ep, conv);

    for (int r = 0; r < 8; r++) begin
      fill_tgt();
      for (int e = 0; e < ME; e++) begin
        int m = $urandom_range(1, 8);
        for (int s = 0; s < NS; s++)
          out_tab[e][s] = mk_out(tgt_mem[s],
                                 int'($urandom_range(0, 2 * m)) - m,
                                 int'($urandom_range(0, 2 * m)) - m,
                                 int'($urandom_range(0, 2 * m)) - m);
      end
      train_run($sformatf("rnd%0d", r), 1'b0, 1'b0, ep, conv);
      v = N_OUT*DW'({$urandom, $urandom});
      infer_run($sformatf("rinf%0d", r), v);
    end

    fill_delta(20, 0, 0, 1'b0);
    go = 1'b1;
    step();
    go = 1'b0;
    n = 1;
    wait_evt(n);
    for (pass = 0; pass < 9 && ann_start; pass++) begin
      ann_out = out_tab[0][pass % NS];
      ann_done = 1'b1;
      step();
      ann_done = 1'b0;
      n = 1;
      wait_evt(n);
    end
    chk("rst_pre_epoch", epoch_cnt, 1);
    chk("rst_pre_start", ann_start, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {ann_start, busy, epoch_cnt, samp_idx}, '0);
    #1 rst_n = 1'b1;
    step();
    step();
    chk("rst_stay_idle", {ann_start, busy}, 2'b00);

    fill_delta(2, 2, 2, 1'b0);
    go = 1'b1;
    step();
    go = 1'b0;
    n = 1;
    wait_evt(n);
    chk("to_start", ann_start, 1'b1);
    n = 0;
    while (!fault && n < 200) begin
      step();
      n++;
    end
    chk("to_cycles", n, TO);
    chk("to_status", {fault, ann_start, busy}, 3'b100);
    train_run("restart", 1'b0, 1'b0, ep, conv);
    chk("restart_conv", {conv, ep[2:0]}, 4'b1001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
